// File: rtl/us_echo_emulator.sv
// us_echo_emulator: sensor-side stand-in for an HC-SR04-class ultrasonic ranger.
// It accepts a trig pulse and answers with an echo pulse whose width encodes the
// programmed distance in cm, or a fixed timeout width when no target is present.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   trig           trigger from the telemeter controller (asynchronous to clk)
//   distance_cm    emulated target distance in cm
//   target_present 1 = target present, 0 = force the timeout echo
//   echo           echo pulse to the controller (registered)
//   busy           high whenever the FSM is not idle (registered)
//   short_trig     one-cycle pulse when a too-short trig pulse is rejected (registered)
module us_echo_emulator #(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned TRIG_MIN_US = 10,
    parameter int unsigned BURST_US    = 200,
    parameter int unsigned US_PER_CM   = 58,
    parameter int unsigned MAX_CM      = 400,
    parameter int unsigned TIMEOUT_US  = 38000,
    parameter int unsigned HOLDOFF_US  = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trig,
    input  logic [9:0] distance_cm,
    input  logic       target_present,
    output logic       echo,
    output logic       busy,
    output logic       short_trig
);

    localparam int unsigned CYC_US       = CLK_FREQ_HZ / 1000000;
    localparam int unsigned TRIG_MIN_CYC = TRIG_MIN_US * CYC_US;
    localparam int unsigned BURST_CYC    = BURST_US * CYC_US;
    localparam int unsigned HOLDOFF_CYC  = HOLDOFF_US * CYC_US;
    localparam int unsigned CM_CYC       = US_PER_CM * CYC_US;
    localparam int unsigned ECHO_MAX_CYC = MAX_CM * CM_CYC;
    localparam int unsigned TIMEOUT_CYC  = TIMEOUT_US * CYC_US;

    // One shared counter must hold the longest interval of any state.
    localparam int unsigned MAX_A   = (ECHO_MAX_CYC > TIMEOUT_CYC) ? ECHO_MAX_CYC : TIMEOUT_CYC;
    localparam int unsigned MAX_B   = (BURST_CYC > HOLDOFF_CYC) ? BURST_CYC : HOLDOFF_CYC;
    localparam int unsigned MAX_C   = (MAX_B > TRIG_MIN_CYC) ? MAX_B : TRIG_MIN_CYC;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    state_t             state;
    logic               trig_meta;
    logic               trig_s;
    logic               trig_q;
    logic [CNT_W-1:0]   cnt;
    logic [9:0]         cm_lat;
    logic               tp_lat;
    logic [CNT_W-1:0]   echo_len_c;

    // Two-flop synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_meta <= 1'b0;
            trig_s    <= 1'b0;
            trig_q    <= 1'b0;
        end else begin
            trig_meta <= trig;
            trig_s    <= trig_meta;
            trig_q    <= trig_s;
        end
    end

    // Echo width from the values latched at trig fall; product kept at full width.
    always_comb begin
        echo_len_c = CNT_W'(TIMEOUT_CYC);
        if (tp_lat && (cm_lat != 10'd0) && (32'(cm_lat) <= MAX_CM)) begin
            echo_len_c = CNT_W'(32'(cm_lat) * CM_CYC);
        end
    end

    // Measurement sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            echo       <= 1'b0;
            busy       <= 1'b0;
            short_trig <= 1'b0;
            cm_lat     <= '0;
            tp_lat     <= 1'b0;
        end else begin
            short_trig <= 1'b0;
            case (state)
                IDLE: begin
                    // trig_q tracks trig_s in every state, so a trig that was
                    // already high when IDLE is entered does not look like a rise.
                    if (trig_s && !trig_q) begin
                        state <= TRIG_HI;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                TRIG_HI: begin
                    if (trig_s) begin
                        if (cnt < CNT_W'(TRIG_MIN_CYC)) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (cnt >= CNT_W'(TRIG_MIN_CYC)) begin
                        cm_lat <= distance_cm;
                        tp_lat <= target_present;
                        cnt    <= '0;
                        state  <= BURST;
                    end else begin
                        short_trig <= 1'b1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                BURST: begin
                    if (cnt == CNT_W'(BURST_CYC - 1)) begin
                        cnt   <= '0;
                        echo  <= 1'b1;
                        state <= ECHO;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ECHO: begin
                    if (cnt == echo_len_c - CNT_W'(1)) begin
                        cnt   <= '0;
                        echo  <= 1'b0;
                        state <= HOLDOFF;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt == CNT_W'(HOLDOFF_CYC - 1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    echo  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/us_echo_emulator.md
Name: us_echo_emulator

Overview:
- Behavioural and synthesizable stand-in for an HC-SR04-class ultrasonic ranging sensor; the sensor-side counterpart of the ultrasonic telemeter controller.
- Accepts the controller's trig pulse and answers with an echo pulse whose width encodes a programmed distance in cm.
- Used on-board, driven from slider switches, for closed-loop checks of the telemeter without the physical sensor, and in simulation.

Parameters:
- CLK_FREQ_HZ, 50000000: clock frequency; CYC_US = CLK_FREQ_HZ/1000000 cycles per microsecond (integer).
- TRIG_MIN_US, 10: minimum trig high time for a valid trigger.
- BURST_US, 200: delay from trig fall to echo rise (8 x 40 kHz burst).
- US_PER_CM, 58: echo microseconds per cm of distance.
- MAX_CM, 400: largest distance that returns a proportional echo.
- TIMEOUT_US, 38000: echo width when there is no target or distance is out of range.
- HOLDOFF_US, 10000: dead time after echo fall during which trig is ignored.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- trig  in  1  trigger from the telemeter controller (asynchronous to clk)
- distance_cm  in  10  emulated target distance in cm
- target_present  in  1  1 = target present; 0 = force timeout echo
- echo  out  1  echo pulse to the controller
- busy  out  1  high whenever state != IDLE
- short_trig  out  1  one-cycle pulse when a trig pulse shorter than TRIG_MIN_US is rejected

Behaviour:
- Reset: echo=0, busy=0, short_trig=0, state=IDLE, all counters=0. A reset asserted in any state aborts the measurement in the cycle it is sampled. echo drops on the next edge.
- trig synchronization:
  - trig passes through a 2-FF synchronizer, giving trig_s.
  - Edges are detected on trig_s against its previous value, adding 3 cycles of latency from the pin.
- IDLE:
  - On a rising edge of trig_s, go to TRIG_HI and clear the width counter.
- TRIG_HI:
  - Count cycles while trig_s=1. The counter saturates at TRIG_MIN_US*CYC_US.
  - On a falling edge with count >= TRIG_MIN_US*CYC_US: latch distance_cm and target_present, then go to BURST with the counter cleared.
  - On a falling edge with count below the minimum: pulse short_trig for 1 cycle and return to IDLE.
- BURST:
  - Wait exactly BURST_US*CYC_US cycles, then go to ECHO.
  - echo rises on the first cycle of ECHO (registered output).
- ECHO:
  - echo=1 for exactly W cycles, then go to HOLDOFF with echo=0.
  - W = latched_cm*US_PER_CM*CYC_US if target_present=1 and 1 <= latched_cm <= MAX_CM.
  - Otherwise W = TIMEOUT_US*CYC_US; this covers cm=0, cm>MAX_CM and target absent.
  - The product is computed at full width with no truncation: 400*58*50 = 1160000 needs 21 bits. The counter is sized by a clog2 of the larger of the max-distance and timeout products.
- HOLDOFF:
  - Wait HOLDOFF_US*CYC_US cycles, then go to IDLE.
  - On the IDLE-entry cycle a trig_s that is already high is not treated as a rising edge. A new low-to-high transition is required.
- Trig edges in BURST, ECHO or HOLDOFF are ignored (no retrigger, no short_trig).
- Changes to distance_cm or target_present after the trig fall do not affect the measurement in flight.
- A trig held high indefinitely keeps the block in TRIG_HI with busy=1 and no echo.

Test Plan:
- Reset, then trig high for 12 us (600 cycles), distance_cm=10, target_present=1 -> echo rises 10000 cycles + sync latency after trig fall; echo width exactly 29000 cycles; busy high from trig rise until HOLDOFF ends.
- Trig high for 5 us (250 cycles) -> short_trig one-cycle pulse, echo stays 0, return to IDLE; a following 12 us trig is accepted normally.
- distance_cm=0, then distance_cm=401, then target_present=0 (three separate triggers) -> echo width 1900000 cycles each time; distance_cm=400 -> 1160000 cycles.
- Change distance_cm 10->200 during BURST and a second trig pulse during ECHO -> echo width stays 29000 cycles; no second echo; no short_trig.
- Assert reset for 1 cycle mid-ECHO -> echo=0 and busy=0 on the following edge; next valid trig yields a normal echo.
- Trig rises during HOLDOFF and stays high past HOLDOFF end -> no measurement until trig falls and rises again.
